// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 clock conditioning: two-flop synchroniser, FILTER_LEN-sample glitch filter, falling-edge pulse.
// Pin fall to fall pulse is FILTER_LEN+2 cycles; no backpressure, the pulse is a single cycle.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The run counter only advances while the synchronised level disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames -> E0/F0-folded key events in a FIFO popped by valid/ready.
// Stop-bit event to code_valid is 2 cycles; a push into a full FIFO without a pop is dropped and flagged.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_keyboard,
  input  logic       data,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_error,
  output logic       overflow
);
  import ps2_pkg::*;

  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic kb_fall;
  logic dat_s1_q, dat_s2_q;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (clk_keyboard),
    .fall (kb_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      dat_s1_q <= data;
      dat_s2_q <= dat_s1_q;
    end
  end

  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_err_q;
  logic [TW-1:0] tmo_q;
  logic          byte_vld_q;
  logic          frame_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      tmo_q         <= '0;
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (state_q == IDLE || kb_fall) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (kb_fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
              par_err_q <= 1'b0;
            end
          end
          DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_err_q <= ~(^shift_q ^ dat_s2_q);
            state_q   <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (dat_s2_q && !par_err_q) byte_vld_q    <= 1'b1;
            else                        frame_error_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_q       <= IDLE;
        frame_error_q <= 1'b1;
      end
    end
  end

  // shift_q still holds the completed byte in the cycle byte_vld_q is high.
  logic     ext_q, ext_d, brk_q, brk_d;
  logic     push_vld;
  ps2_evt_t push_evt;

  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    push_vld      = 1'b0;
    push_evt.ext  = ext_q;
    push_evt.brk  = brk_q;
    push_evt.code = shift_q;
    if (frame_error_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push_vld = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  // Shift-register FIFO: entry 0 is the head, so the outputs come straight from flops.
  ps2_evt_t         ent_q [FIFO_DEPTH];
  ps2_evt_t         ent_d [FIFO_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic             pop, full, do_push;

  always_comb begin
    pop     = valid_q && code_ready;
    full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    do_push = push_vld && (!full || pop);
    ovf_d   = push_vld && full && !pop;
    wr_idx  = pop ? cnt_q - CNT_W'(1) : cnt_q;
    ent_d   = ent_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (do_push && wr_idx == CNT_W'(i)) ent_d[i] = push_evt;
    end
    cnt_d = cnt_q;
    if (do_push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && pop) cnt_d = cnt_q - CNT_W'(1);
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ent_q   <= ent_d;
    end
  end

  assign code        = ent_q[0].code;
  assign is_break    = ent_q[0].brk;
  assign is_extended = ent_q[0].ext;
  assign code_valid  = valid_q;
  assign frame_error = frame_error_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: scenario tasks plus an event scoreboard.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int FL    = 4;
  localparam int TMO   = 500;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_keyboard = 1'b1;
  logic       data = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code;
  logic       is_break, is_extended, code_valid, frame_error, overflow;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;
  ps2_evt_t exp_q[$];
  ps2_evt_t mon_e;

  always #5 clk = ~clk;

  ps2_scancode_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_keyboard(clk_keyboard),
    .data        (data),
    .code        (code),
    .is_break    (is_break),
    .is_extended (is_extended),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .frame_error (frame_error),
    .overflow    (overflow)
  );

  function automatic ps2_evt_t mk(input logic e, input logic b, input logic [7:0] c);
    ps2_evt_t r;
    r.ext  = e;
    r.brk  = b;
    r.code = c;
    return r;
  endfunction

  // Scoreboard: every accepted pop is compared against the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error) fe_cnt++;
      if (overflow) ovf_cnt++;
      if (code_valid && code_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got code=%h brk=%b ext=%b, required no event",
                   code, is_break, is_extended);
        end else begin
          mon_e = exp_q.pop_front();
          if ({is_extended, is_break, code} !== {mon_e.ext, mon_e.brk, mon_e.code}) begin
            errors++;
            $display("FAIL event: got code=%h brk=%b ext=%b, required code=%h brk=%b ext=%b",
                     code, is_break, is_extended, mon_e.code, mon_e.brk, mon_e.ext);
          end
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    data = b;
    repeat (HALF) @(posedge clk);
    #1 clk_keyboard = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 clk_keyboard = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (2 * HALF) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({code, is_break, is_extended, code_valid, frame_error, overflow} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {code, is_break, is_extended, code_valid, frame_error, overflow});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got valid=%b ferr=%b, required 0 0", code_valid, frame_error);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_plain();
    int first_hi;
    int hi_cnt;
    logic [7:0] b;
    b = 8'h1C;
    code_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, b));
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 clk_keyboard = 1'b0;
    first_hi = -1;
    hi_cnt = 0;
    for (int k = 1; k <= FL + 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (code_valid) begin
        if (first_hi < 0) first_hi = k;
        hi_cnt++;
      end
    end
    @(posedge clk);
    #1 clk_keyboard = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
    checks++;
    if (first_hi != FL + 4) begin
      errors++;
      $display("FAIL plain_latency: got %0d cycles, required %0d", first_hi, FL + 4);
    end
    checks++;
    if (hi_cnt != 1) begin
      errors++;
      $display("FAIL plain_valid_width: got %0d cycles, required 1", hi_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL plain_missing: got %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_break_ext();
    int fe0;
    fe0 = fe_cnt;
    code_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 8'h1C));
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 8'h75));
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++;
    if (exp_q.size() != 0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL break_ext: got pending=%0d ferr=%0d, required 0 0", exp_q.size(), fe_cnt - fe0);
    end
  endtask

  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt;
    code_ready = 1'b1;
    send_frame(8'h1C, 1'b1);
    checks++;
    if (fe_cnt != fe0 + 1) begin
      errors++;
      $display("FAIL parity_error: got %0d pulses, required 1", fe_cnt - fe0);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 8'h32));
    send_frame(8'h32, 1'b0);
    checks++;
    if (exp_q.size() != 0 || fe_cnt != fe0 + 1) begin
      errors++;
      $display("FAIL parity_recover: got pending=%0d ferr=%0d, required 0 1", exp_q.size(), fe_cnt - fe0);
    end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_cnt;
    code_ready = 1'b1;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    data = 1'b1;
    repeat (TMO - 100) @(posedge clk);
    #1;
    checks++;
    if (fe_cnt != fe0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses, required 0", fe_cnt - fe0);
    end
    repeat (150) @(posedge clk);
    #1;
    checks++;
    if (fe_cnt != fe0 + 1) begin
      errors++;
      $display("FAIL timeout_error: got %0d pulses, required 1", fe_cnt - fe0);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_recover: got %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    o0 = ovf_cnt;
    code_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, codes[i]));
      send_frame(codes[i], 1'b0);
    end
    checks++;
    if (ovf_cnt != o0) begin
      errors++;
      $display("FAIL overflow_early: got %0d pulses, required 0", ovf_cnt - o0);
    end
    send_frame(codes[4], 1'b0);
    checks++;
    if (ovf_cnt != o0 + 1) begin
      errors++;
      $display("FAIL overflow_pulse: got %0d pulses, required 1", ovf_cnt - o0);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (code_valid !== 1'b1 || code !== 8'h15 || is_break !== 1'b0 || is_extended !== 1'b0) begin
        errors++;
        $display("FAIL stall_stable: got valid=%b code=%h, required 1 15", code_valid, code);
      end
    end
    @(posedge clk);
    #1 code_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: got pending=%0d valid=%b, required 0 0", exp_q.size(), code_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_glitch_reset();
    int fe0;
    fe0 = fe_cnt;
    code_ready = 1'b1;
    data = 1'b0;
    @(posedge clk);
    #1 clk_keyboard = 1'b0;
    repeat (2) @(posedge clk);
    #1 clk_keyboard = 1'b1;
    repeat (30) @(posedge clk);
    #1 data = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0);
    checks++;
    if (exp_q.size() != 0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL glitch: got pending=%0d ferr=%0d, required 0 0", exp_q.size(), fe_cnt - fe0);
    end
    code_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h15));
    send_frame(8'h15, 1'b0);
    send_frame(8'hF0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    checks++;
    if (code_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_queued: got valid=%b, required 1", code_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    data = 1'b1;
    clk_keyboard = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({code, is_break, is_extended, code_valid, frame_error, overflow} !== 13'h0) begin
      errors++;
      $display("FAIL midframe_reset: got %h, required 0",
               {code, is_break, is_extended, code_valid, frame_error, overflow});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    code_ready = 1'b1;
    fe0 = fe_cnt;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0);
    checks++;
    if (exp_q.size() != 0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL post_reset_frame: got pending=%0d ferr=%0d, required 0 0", exp_q.size(), fe_cnt - fe0);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_break_ext();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
